serial_arith_ctrl: RTL and testbench

//  Sequencer for the bit-serial add/subtract datapath. Takes one operation per request
//  (A, B, op) on a valid/ready handshake and loads the operand shift registers.

---
 rtl/serial_arith_pkg.sv | 30 +++
 rtl/serial_arith_slice.sv | 32 +++
 rtl/serial_arith_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_arith_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial add/subtract sequencer: FSM states, op codes
// and the 1-bit carry/borrow recurrence used by the arithmetic slice.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Add propagates a carry (majority); subtract propagates a borrow.
    function automatic logic slice_carry(
        input logic op,
        input logic a,
        input logic b,
        input logic c
    );
        logic c_next;
        if (op == OP_SUB) begin
            c_next = (~a & b) | (~(a ^ b) & c);
        end else begin
            c_next = (a & b) | (a & c) | (b & c);
        end
        return c_next;
    endfunction

endpackage

// File: rtl/serial_arith_slice.sv
// One-bit serial add/subtract slice: combinational sum/difference bit plus the
// registered carry (add) or borrow (subtract) fed back into the next bit.
import serial_arith_pkg::*;

module serial_arith_slice (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic op,
    input  logic a,
    input  logic b,
    output logic s,
    output logic c_q
);

    logic c_next;

    assign s      = a ^ b ^ c_q;
    assign c_next = slice_carry(op, a, b, c_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= 1'b0;
        end else if (clr) begin
            c_q <= 1'b0;
        end else if (en) begin
            c_q <= c_next;
        end
    end

endmodule

// File: rtl/serial_arith_ctrl.sv
// Sequencer for the bit-serial add/subtract datapath: accepts one op, steps the
// slice LSB-first for W cycles, holds the result. SERIAL_ARITH_OVF_EN adds res_ovf.
import serial_arith_pkg::*;

module serial_arith_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_cout,
`ifdef SERIAL_ARITH_OVF_EN
    output logic         res_ovf,
`endif
    output logic         busy
);

    localparam int CNT_W = $clog2(W) + 1;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     res_reg;
    logic             op_reg;

    logic             accept;
    logic             shift_en;
    logic             last_bit;
    logic             sum_bit;
    logic             carry_q;

    assign accept   = req_valid & req_ready;
    assign shift_en = (state_reg == SHIFT);
    assign last_bit = shift_en && (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Ready is masked by rst so nothing is accepted during the reset cycle.
    always_comb begin
        req_ready = (state_reg == IDLE) && !rst;
        busy      = (state_reg == SHIFT);
        res_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            op_reg  <= OP_ADD;
            cnt_reg <= '0;
        end else if (accept) begin
            a_reg   <= req_a;
            b_reg   <= req_b;
            op_reg  <= req_op;
            cnt_reg <= CNT_W'(W - 1);
        end else if (shift_en) begin
            a_reg   <= {1'b0, a_reg[W-1:1]};
            b_reg   <= {1'b0, b_reg[W-1:1]};
            res_reg <= {sum_bit, res_reg[W-1:1]};
            // Counter parks at zero rather than wrapping on the final bit.
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    end

    serial_arith_slice u_slice (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (shift_en),
        .op  (op_reg),
        .a   (a_reg[0]),
        .b   (b_reg[0]),
        .s   (sum_bit),
        .c_q (carry_q)
    );

    // The slice carry only moves in SHIFT or on accept, so after the last bit
    // it is the carry/borrow out of the MSB and stays put through DONE.
    assign res_data = res_reg;
    assign res_cout = carry_q;

`ifdef SERIAL_ARITH_OVF_EN
    logic msb_c_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            msb_c_reg <= 1'b0;
        end else if (last_bit) begin
            msb_c_reg <= carry_q;
        end
    end

    assign res_ovf = msb_c_reg ^ carry_q;
`endif

endmodule

// File: tb/tb_serial_arith_ctrl.sv
// Self-checking bench for serial_arith_ctrl (W=8): scoreboard of expected results
// pushed on each accepted request, popped when the controller retires a result.
module tb_serial_arith_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_cout;
    logic         busy;
`ifdef SERIAL_ARITH_OVF_EN
    logic         res_ovf;
`endif

    serial_arith_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_cout  (res_cout),
`ifdef SERIAL_ARITH_OVF_EN
        .res_ovf   (res_ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct packed {
        logic [W-1:0] data;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic, independent of the serial recurrence.
    function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       m;
        logic [W:0] r;
        if (op) r = {1'b0, a} - {1'b0, b};
        else    r = {1'b0, a} + {1'b0, b};
        m.data = r[W-1:0];
        m.cout = op ? (a < b) : r[W];
        m.ovf  = op ? ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1]))
                    : ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
        return m;
    endfunction

    // Monitor: pushes on handshake, checks latency/busy width, pops on retire.
    int   accept_cyc = 0;
    int   busy_cnt   = 0;
    logic prev_rv    = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            busy_cnt = 0;
            prev_rv  = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (req_valid && req_ready) begin
                accept_cyc = cyc + 1;
                acc_q.push_back(cyc + 1);
                sb_q.push_back(model(req_op, req_a, req_b));
                busy_cnt = 0;
            end
            if (res_valid && !prev_rv) begin
                chk("latency", cyc - accept_cyc, W);
                chk("busy_cycles", busy_cnt, W);
                busy_cnt = 0;
            end
            if (res_valid && res_ready) begin
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    $display("retire: data=%02h cout=%0b exp data=%02h cout=%0b",
                             res_data, res_cout, mon_e.data, mon_e.cout);
                    chk("res_data", res_data, mon_e.data);
                    chk("res_cout", res_cout, mon_e.cout);
`ifdef SERIAL_ARITH_OVF_EN
                    chk("res_ovf", res_ovf, mon_e.ovf);
`endif
                end
            end
            prev_rv = res_valid;
        end
    end

    // Caller must be just after a posedge; returns just after the accept edge.
    task automatic send(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        chk("accept_timeout", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    int retire_cyc;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_cout", res_cout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        @(posedge clk);
        #1;

        // Directed arithmetic cases, res_ready tied high.
        send(1'b0, 8'h3C, 8'h05); drain();
        send(1'b1, 8'h05, 8'h0A); drain();
        send(1'b0, 8'hFF, 8'h01); drain();
        send(1'b1, 8'h80, 8'h01); drain();
        send(1'b0, 8'h7F, 8'h01); drain();
        send(1'b0, 8'h10, 8'h20); drain();
        send(1'b1, 8'h00, 8'h00); drain();
        send(1'b1, 8'h7F, 8'hFF); drain();
        for (int i = 0; i < 8; i++) begin
            send(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            drain();
        end

        // Back-pressure: result held in DONE, second request waits for IDLE.
        res_ready = 1'b0;
        send(1'b0, 8'hA5, 8'h5A);
        req_op    = 1'b1;
        req_a     = 8'h10;
        req_b     = 8'h20;
        req_valid = 1'b1;
        repeat (W) begin
            @(negedge clk);
            chk("ready_low_shift", req_ready, 0);
        end
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, 8'hFF);
            chk("hold_cout", res_cout, 0);
            chk("hold_ready_low", req_ready, 0);
            chk("hold_not_accepted", sb_q.size(), 1);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        retire_cyc = cyc;
        @(negedge clk);
        chk("idle_after_retire_valid", res_valid, 0);
        chk("idle_after_retire_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain();
        chk("accept_after_retire", acc_q[acc_q.size()-1], retire_cyc + 1);

        // Abort: rst sampled on the 4th SHIFT edge.
        send(1'b0, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", res_valid, 0);
        chk("abort_data", res_data, 0);
        chk("abort_cout", res_cout, 0);
        chk("abort_ready", req_ready, 1);
`ifdef SERIAL_ARITH_OVF_EN
        chk("abort_ovf", res_ovf, 0);
`endif
        @(posedge clk);
        #1;
        send(1'b0, 8'h01, 8'h01); drain();

        // Back-to-back throughput.
        acc_q.delete();
        send(1'b0, 8'h11, 8'h22);
        send(1'b1, 8'h33, 8'h44);
        send(1'b0, 8'h80, 8'h80);
        drain();
        chk("b2b_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            chk("b2b_space0", acc_q[1] - acc_q[0], W + 2);
            chk("b2b_space1", acc_q[2] - acc_q[1], W + 2);
        end

        chk("sb_empty_end", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
